// File: rtl/permute_round_ctrl.sv
// Multi-round controller for the encoder permute stage: load, start instances, wait, store, repeat.
// Optional WAIT-state watchdog is compiled in with `define PERMUTE_WATCHDOG_EN.
module permute_round_ctrl #(
  parameter int NUM_INST       = 5,
  parameter int NUM_ROUNDS     = 24,
  parameter int RW             = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [NUM_INST-1:0] inst_done,
  output logic                read_mem,
  output logic                start_instances,
  output logic                write_mem,
  output logic [RW-1:0]       round_idx,
  output logic                busy,
  output logic                done,
  output logic                timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_STORE
  } state_e;

  localparam logic [RW-1:0] LAST_ROUND = RW'(NUM_ROUNDS - 1);

  state_e              state_q, state_d;
  logic [RW-1:0]       round_idx_q, round_idx_d;
  logic [NUM_INST-1:0] done_seen_q, done_seen_d;
  logic                all_done;
  logic                wd_fire;

  // A done arriving in the current WAIT cycle counts immediately, so no pulse is lost.
  assign all_done = &(done_seen_q | inst_done);

`ifdef PERMUTE_WATCHDOG_EN
  localparam int WCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(TIMEOUT_CYCLES - 1);

  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           timeout_err_q, timeout_err_d;

  assign wd_fire = (state_q == S_WAIT) && !all_done && (wait_cnt_q == WAIT_LIMIT);

  always_comb begin
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
    if (state_q == S_START) begin
      wait_cnt_d = '0;
    end else if ((state_q == S_WAIT) && !all_done) begin
      wait_cnt_d = wait_cnt_q + WCW'(1);
    end
    // abort wins over the watchdog, so the error is only flagged for a real timeout exit
    if ((state_q == S_IDLE) && start) begin
      timeout_err_d = 1'b0;
    end else if (wd_fire && !abort) begin
      timeout_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign wd_fire            = 1'b0;
  assign timeout_err        = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    round_idx_d     = round_idx_q;
    done_seen_d     = done_seen_q;
    read_mem        = 1'b0;
    start_instances = 1'b0;
    write_mem       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        read_mem    = 1'b1;
        done_seen_d = '0;
        state_d     = S_START;
      end
      S_START: begin
        start_instances = 1'b1;
        done_seen_d     = done_seen_q | inst_done;
        state_d         = S_WAIT;
      end
      S_WAIT: begin
        done_seen_d = done_seen_q | inst_done;
        if (all_done) begin
          state_d = S_STORE;
        end else if (wd_fire) begin
          state_d     = S_IDLE;
          round_idx_d = '0;
          done_seen_d = '0;
        end
      end
      S_STORE: begin
        write_mem = 1'b1;
        if (round_idx_q == LAST_ROUND) begin
          round_idx_d = '0;
          state_d     = S_IDLE;
        end else begin
          round_idx_d = round_idx_q + RW'(1);
          state_d     = S_LOAD;
        end
      end
      default: begin
        state_d     = S_IDLE;
        round_idx_d = '0;
        done_seen_d = '0;
      end
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      round_idx_d = '0;
      done_seen_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      round_idx_q <= '0;
      done_seen_q <= '0;
    end else begin
      state_q     <= state_d;
      round_idx_q <= round_idx_d;
      done_seen_q <= done_seen_d;
    end
  end

  assign round_idx = round_idx_q;
  assign done      = (state_q == S_IDLE);
  assign busy      = ~done;

  a_strobes_onehot0 : assert property (@(posedge clk) disable iff (rst)
    $onehot0({read_mem, start_instances, write_mem}));

  a_idle_round_zero : assert property (@(posedge clk) disable iff (rst)
    done |-> (round_idx == '0));

endmodule

// File: tb/tb_permute_round_ctrl.sv
// Scoreboard bench for permute_round_ctrl: a round-timeline model predicts every strobe and
// the done edge; a monitor compares them against the DUT as they appear.
module tb_permute_round_ctrl;

  localparam int NI  = 5;
  localparam int NR  = 3;
  localparam int TO  = 8;
  localparam int RWD = (NR > 1) ? $clog2(NR) : 1;

  localparam int K_LOAD  = 0;
  localparam int K_START = 1;
  localparam int K_STORE = 2;
  localparam int K_END   = 3;

  localparam int M_RANDOM  = 0;
  localparam int M_UNIFORM = 1;
  localparam int M_STAGGER = 2;
  localparam int M_STUCK   = 3;

`ifdef PERMUTE_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  typedef struct packed {
    int   kind;
    int   rnd;
    int   cyc;
    logic tmo;
  } ev_t;

  // Per-instance pulse offset within a round: 0 = START cycle, n = n-th WAIT cycle, F = never.
  typedef logic [NI-1:0][3:0] dly_t;

  logic           clk;
  logic           rst;
  logic           start;
  logic           abort;
  logic [NI-1:0]  inst_done;
  logic           read_mem;
  logic           start_instances;
  logic           write_mem;
  logic [RWD-1:0] round_idx;
  logic           busy;
  logic           done;
  logic           timeout_err;

  ev_t  exp_q[$];
  dly_t dly_q[$];
  int   cyc;
  int   n_vec;
  int   n_err;
  bit   mon_en;
  logic sticky_exp;
  logic prev_done;

  permute_round_ctrl #(
    .NUM_INST      (NI),
    .NUM_ROUNDS    (NR),
    .RW            (RWD),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .inst_done      (inst_done),
    .read_mem       (read_mem),
    .start_instances(start_instances),
    .write_mem      (write_mem),
    .round_idx      (round_idx),
    .busy           (busy),
    .done           (done),
    .timeout_err    (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic dly_t makeDelays(input int mode);
    dly_t d;
    int   st[NI] = '{1, 3, 3, 7, 9};
    for (int i = 0; i < NI; i++) begin
      case (mode)
        M_UNIFORM: d[i] = 4'd2;
        M_STAGGER: d[i] = 4'(st[i]);
        M_STUCK:   d[i] = 4'hF;
        default:   d[i] = 4'($urandom_range(0, 9));
      endcase
    end
    return d;
  endfunction

  // WAIT cycles spent in a round: until the latest instance has reported, at least one.
  function automatic int roundWait(input dly_t d);
    int w = 1;
    for (int i = 0; i < NI; i++) begin
      if (d[i] == 4'hF) return 1000;
      if (int'(d[i]) > w) w = int'(d[i]);
    end
    return w;
  endfunction

  task automatic pushEv(input int kind, input int rnd, input int c, input logic tmo);
    ev_t e;
    e.kind = kind;
    e.rnd  = rnd;
    e.cyc  = c;
    e.tmo  = tmo;
    exp_q.push_back(e);
  endtask

  // Reference timeline: a round is LOAD, START, W WAIT cycles, STORE; watchdog ends a round with W > TO.
  task automatic planRun(input int s0, input int mode, input int nr, input bit with_end,
                         output int s_next);
    int   s;
    int   w;
    dly_t d;
    s = s0;
    for (int r = 0; r < nr; r++) begin
      d = makeDelays(mode);
      w = roundWait(d);
      dly_q.push_back(d);
      pushEv(K_LOAD, r, s, 1'b0);
      pushEv(K_START, r, s + 1, 1'b0);
      if (WD && (w > TO)) begin
        pushEv(K_END, 0, s + 2 + TO, 1'b1);
        s_next = s + 2 + TO;
        return;
      end
      pushEv(K_STORE, r, s + 2 + w, 1'b0);
      s = s + 3 + w;
    end
    if (with_end) pushEv(K_END, 0, s, 1'b0);
    s_next = s;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (!done && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_reached", int'(done), 1);
  endtask

  task automatic applyStimulus(input int mode, input bit hold, input bit do_abort);
    int   s;
    int   s1;
    int   d_end;
    int   d_end2;
    int   abort_c;
    int   last;
    dly_t d;
    waitIdle();
    repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    start   = 1'b1;
    s       = cyc + 1;
    abort_c = -100;
    d_end2  = 0;
    if (do_abort) begin
      planRun(s, M_UNIFORM, 1, 1'b0, s1);
      for (int i = 0; i < NI; i++) d[i] = 4'($urandom_range(4, 9));
      dly_q.push_back(d);
      pushEv(K_LOAD, 1, s1, 1'b0);
      pushEv(K_START, 1, s1 + 1, 1'b0);
      abort_c = s1 + 4;
      pushEv(K_END, 0, abort_c + 1, 1'b0);
      d_end = abort_c + 1;
    end else begin
      planRun(s, mode, NR, 1'b1, d_end);
    end
    if (hold) planRun(d_end + 1, M_RANDOM, NR, 1'b1, d_end2);
    last = hold ? d_end2 : d_end;
    while (cyc <= last) begin
      @(negedge clk);
      abort = (cyc == abort_c);
      if (hold && (cyc <= d_end)) start = 1'b1;
      else if (cyc < last)        start = 1'($urandom_range(0, 1));
      else                        start = 1'b0;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  // Instance model: replays the planned pulses after each start_instances, plus ignorable noise.
  initial begin
    dly_t          cur;
    int            j;
    bit            active;
    logic [NI-1:0] v;
    cur       = '1;
    j         = 0;
    active    = 1'b0;
    inst_done = '0;
    forever begin
      @(negedge clk);
      v = '0;
      if (start_instances) begin
        if (dly_q.size() > 0) cur = dly_q.pop_front();
        else                  cur = '1;
        active = 1'b1;
        j      = 0;
      end
      if (active) begin
        for (int i = 0; i < NI; i++) begin
          if ((cur[i] != 4'hF) && (int'(cur[i]) == j)) v[i] = 1'b1;
        end
        j++;
        if (j > 15) active = 1'b0;
      end
      if (read_mem || write_mem || (done && ($urandom_range(0, 3) == 0))) v = NI'($urandom);
      inst_done = v;
    end
  end

  initial begin
    int  kind;
    ev_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        kind = -1;
        if (read_mem)                  kind = K_LOAD;
        else if (start_instances)      kind = K_START;
        else if (write_mem)            kind = K_STORE;
        else if (done && !prev_done)   kind = K_END;
        if (kind >= 0) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_event", kind, -1);
          end else begin
            e = exp_q.pop_front();
            checkOutput("event_kind", kind, e.kind);
            checkOutput("event_cycle", cyc, e.cyc);
            if (kind != K_END) checkOutput("event_round", int'(round_idx), e.rnd);
            else               sticky_exp = e.tmo;
          end
        end
        checkOutput("busy_vs_done", int'(busy), int'(!done));
        checkOutput("strobe_onehot0", int'($onehot0({read_mem, start_instances, write_mem})), 1);
        if (done) begin
          checkOutput("idle_round_idx", int'(round_idx), 0);
          checkOutput("idle_strobes", int'({read_mem, start_instances, write_mem}), 0);
        end
        checkOutput("timeout_err", int'(timeout_err), done ? int'(sticky_exp) : 0);
        prev_done = done;
      end
    end
  end

  initial begin
    n_vec      = 0;
    n_err      = 0;
    mon_en     = 1'b0;
    sticky_exp = 1'b0;
    prev_done  = 1'b1;
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_done", int'(done), 1);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_strobes", int'({read_mem, start_instances, write_mem}), 0);
    checkOutput("reset_round_idx", int'(round_idx), 0);
    checkOutput("reset_timeout_err", int'(timeout_err), 0);
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] uniform, staggered and abort runs");
    applyStimulus(M_UNIFORM, 1'b0, 1'b0);
    applyStimulus(M_STAGGER, 1'b0, 1'b0);
    applyStimulus(M_RANDOM, 1'b0, 1'b1);
    applyStimulus(M_UNIFORM, 1'b0, 1'b0);
    $display("[TB] start held across a run, then random runs");
    applyStimulus(M_RANDOM, 1'b1, 1'b0);
    repeat (6) applyStimulus(M_RANDOM, 1'b0, 1'b0);
`ifdef PERMUTE_WATCHDOG_EN
    $display("[TB] watchdog with stuck instances");
    applyStimulus(M_STUCK, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    applyStimulus(M_UNIFORM, 1'b0, 1'b0);
`endif
    repeat (5) @(negedge clk);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/permute_round_ctrl.md
Name: permute_round_ctrl

Overview:
- Multi-round control unit for the encoder permute stage.
- Per round: loads state from memory, pulses start to NUM_INST parallel permute instances, and aggregates their done flags (sticky).
- Writes the result back after each round; repeats for NUM_ROUNDS rounds, then returns to idle with done high.
- Generalises the single-shot permute controller with per-instance done aggregation, round counting, write-back, abort and an optional watchdog.

Parameters:
- NUM_INST, 5: number of permute instances; width of inst_done.
- NUM_ROUNDS, 24: rounds per accepted start; legal range ≥1.
- RW, $clog2(NUM_ROUNDS) clamped to minimum 1: width of round_idx.
- TIMEOUT_CYCLES, 256: WAIT-state watchdog limit; used only with PERMUTE_WATCHDOG_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  level request; sampled only in IDLE.
- abort  in  1  synchronous cancel; effective in any non-IDLE state.
- inst_done  in  NUM_INST  per-instance completion; pulse or level.
- read_mem  out  1  one-cycle load strobe (LOAD state).
- start_instances  out  1  one-cycle start pulse to all instances (START state).
- write_mem  out  1  one-cycle write-back strobe (STORE state).
- round_idx  out  RW  current round, 0..NUM_ROUNDS-1.
- busy  out  1  equals ~done.
- done  out  1  high in IDLE.
- timeout_err  out  1  sticky watchdog error; constant 0 without the macro.

Behaviour:
- Reset (async): state=IDLE, round_idx=0, done_seen=0, timeout_err=0. Outputs: done=1, busy=0, read_mem=start_instances=write_mem=0.
- Outputs are Moore, decoded from state only. At most one strobe is high per cycle.
- States and transitions:
  - IDLE: start=1 -> LOAD; else stay.
  - LOAD: read_mem=1; clear done_seen -> START.
  - START: start_instances=1 -> WAIT.
  - WAIT: all_done -> STORE; else stay.
  - STORE: write_mem=1. If round_idx==NUM_ROUNDS-1: round_idx<=0 -> IDLE. Else round_idx<=round_idx+1 -> LOAD.
- Done aggregation:
  - done_seen[NUM_INST] ORs in inst_done every cycle in START and WAIT.
  - all_done = &(done_seen | inst_done), combinational, so a final done arriving in a WAIT cycle leaves WAIT on the next edge.
  - Instances finishing at different times must all be counted; pulses are never lost.
  - inst_done in IDLE, LOAD or STORE is ignored.
- Latency: a round costs 3 + W cycles, where W ≥ 1 is the number of WAIT cycles. start sampled at edge 0 with NUM_ROUNDS=1 and immediate done: LOAD c1, START c2, WAIT c3, STORE c4, done=1 in c5.
- start while busy is ignored; no queuing.
- abort=1 in LOAD/START/WAIT/STORE -> IDLE next edge, round_idx<=0, done_seen<=0. A STORE that coincides with abort still shows write_mem for that cycle (Moore). abort in IDLE has no effect. abort has priority over all other transitions.
- round_idx is stable from LOAD through STORE of its round and is valid for memory addressing.
- rst mid-operation returns to reset values immediately; instances may still assert inst_done afterwards, which IDLE ignores.

Optional Feature:
- Macro: PERMUTE_WATCHDOG_EN.
- With macro:
  - wait_cnt is cleared in START and increments each WAIT cycle while !all_done.
  - When wait_cnt==TIMEOUT_CYCLES-1 and !all_done: -> IDLE, set timeout_err, round_idx<=0, no write_mem.
  - timeout_err clears on rst or on the cycle start is accepted in IDLE.
  - abort has priority over timeout.
- Without macro: no counter; WAIT is unbounded; timeout_err is tied to 0.

Test Plan:
- Reset, then idle: done=1, busy=0, all strobes 0, round_idx=0.
- NUM_INST=5, NUM_ROUNDS=3; all inst_done pulse 2 cycles after each start_instances -> exactly 3 read_mem/start_instances/write_mem pulses; round_idx 0,1,2 during write_mem; done rises 1 cycle after the third write_mem.
- Staggered single-cycle pulses on inst_done bits 0..4 at WAIT cycles 1,3,3,7,9 -> write_mem only after bit 4; no premature STORE.
- abort asserted in WAIT of round 1 -> IDLE next cycle, round_idx=0, no write_mem; a new start restarts at round 0.
- start held high across a full run -> a second run begins one cycle after done rises; start pulsed mid-run is ignored.
- PERMUTE_WATCHDOG_EN, TIMEOUT_CYCLES=8, inst_done stuck 0 -> IDLE after 8 WAIT cycles with timeout_err=1, held until the next start.
